// File: rtl/cdb_arbiter_if.sv
// Bundle of FU completion requests and CDB broadcast slots shared by the
// functional units (master side) and the arbiter (slave side).
interface cdb_arbiter_if #(
  parameter int NUM_FU    = 4,
  parameter int NUM_CDB   = 2,
  parameter int PREG_BITS = 6,
  parameter int DATA_BITS = 32
);
  logic [NUM_FU-1:0]                 fu_req;
  logic [NUM_FU-1:0][PREG_BITS-1:0]  fu_dest;
  logic [NUM_FU-1:0][DATA_BITS-1:0]  fu_data;
  logic [NUM_FU-1:0]                 fu_grant;
  logic [NUM_CDB-1:0]                cdb_valid;
  logic [NUM_CDB-1:0][PREG_BITS-1:0] cdb_reg;
  logic [NUM_CDB-1:0][DATA_BITS-1:0] cdb_data;

  modport master (
    output fu_req, fu_dest, fu_data,
    input  fu_grant, cdb_valid, cdb_reg, cdb_data
  );

  modport slave (
    input  fu_req, fu_dest, fu_data,
    output fu_grant, cdb_valid, cdb_reg, cdb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: grants up to NUM_CDB finished FUs per
// cycle starting from a rotating pointer and broadcasts their results one cycle later.
module cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int NUM_CDB   = 2,
  parameter int PREG_BITS = 6,
  parameter int DATA_BITS = 32
) (
  input  logic          clock,
  input  logic          reset,
  cdb_arbiter_if.slave  bus
);
  localparam int PTR_BITS = $clog2(NUM_FU);
  localparam int CNT_BITS = $clog2(NUM_CDB + 1);

  logic [PTR_BITS-1:0]               r_rrPtr;
  logic [NUM_CDB-1:0]                r_cdbValid;
  logic [NUM_CDB-1:0][PREG_BITS-1:0] r_cdbReg;
  logic [NUM_CDB-1:0][DATA_BITS-1:0] r_cdbData;

  logic [NUM_FU-1:0][PTR_BITS-1:0]   w_scanIdx;
  logic [NUM_FU-1:0]                 w_grant;
  logic [NUM_CDB-1:0]                w_slotValid;
  logic [NUM_CDB-1:0][PTR_BITS-1:0]  w_slotIdx;
  logic [PTR_BITS-1:0]               w_lastIdx;
  logic [PTR_BITS-1:0]               w_nextPtr;
  logic [CNT_BITS-1:0]               w_rank;
  logic [PTR_BITS:0]                 w_sum;
  logic                              w_anyGrant;

  // Scan position j maps to FU (rr_ptr + j) mod NUM_FU; works for non-power-of-two NUM_FU.
  always_comb begin
    w_scanIdx = '0;
    w_sum     = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      w_sum = {1'b0, r_rrPtr} + (PTR_BITS+1)'(j);
      if (w_sum >= (PTR_BITS+1)'(NUM_FU))
        w_scanIdx[j] = PTR_BITS'(w_sum - (PTR_BITS+1)'(NUM_FU));
      else
        w_scanIdx[j] = PTR_BITS'(w_sum);
    end
  end

  always_comb begin
    w_grant     = '0;
    w_slotValid = '0;
    w_slotIdx   = '0;
    w_lastIdx   = r_rrPtr;
    w_rank      = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      if (bus.fu_req[w_scanIdx[j]] && (w_rank < CNT_BITS'(NUM_CDB))) begin
        w_grant[w_scanIdx[j]] = 1'b1;
        for (int k = 0; k < NUM_CDB; k++) begin
          if (w_rank == CNT_BITS'(k)) begin
            w_slotValid[k] = 1'b1;
            w_slotIdx[k]   = w_scanIdx[j];
          end
        end
        w_lastIdx = w_scanIdx[j];
        w_rank    = w_rank + CNT_BITS'(1);
      end
    end
  end

  assign w_anyGrant = |w_grant;
  assign w_nextPtr  = (w_lastIdx == PTR_BITS'(NUM_FU - 1)) ? '0 : w_lastIdx + PTR_BITS'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rrPtr    <= '0;
      r_cdbValid <= '0;
      r_cdbReg   <= '0;
      r_cdbData  <= '0;
    end else begin
      if (w_anyGrant)
        r_rrPtr <= w_nextPtr;
      for (int k = 0; k < NUM_CDB; k++) begin
        r_cdbValid[k] <= w_slotValid[k];
        r_cdbReg[k]   <= w_slotValid[k] ? bus.fu_dest[w_slotIdx[k]] : '0;
        r_cdbData[k]  <= w_slotValid[k] ? bus.fu_data[w_slotIdx[k]] : '0;
      end
    end
  end

  // Grants feed the FUs' retire enables, so they must be silenced during reset.
  assign bus.fu_grant  = reset ? '0 : w_grant;
  assign bus.cdb_valid = r_cdbValid;
  assign bus.cdb_reg   = r_cdbReg;
  assign bus.cdb_data  = r_cdbData;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized scoreboard bench for cdb_arbiter: a rotating-list reference model
// predicts grants and next-cycle broadcasts, a monitor compares every cycle.
module tb_cdb_arbiter;
  localparam int NUM_FU    = 4;
  localparam int NUM_CDB   = 2;
  localparam int PREG_BITS = 6;
  localparam int DATA_BITS = 32;

  typedef struct {
    logic [NUM_CDB-1:0]                valid;
    logic [NUM_CDB-1:0][PREG_BITS-1:0] regs;
    logic [NUM_CDB-1:0][DATA_BITS-1:0] data;
  } expEntry_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   mRr;
  int   fu1Wait;
  bit   fairMode;
  logic [NUM_FU-1:0] lastGrant;
  expEntry_t expQ[$];

  cdb_arbiter_if #(.NUM_FU(NUM_FU), .NUM_CDB(NUM_CDB), .PREG_BITS(PREG_BITS),
                   .DATA_BITS(DATA_BITS)) bus();

  cdb_arbiter #(.NUM_FU(NUM_FU), .NUM_CDB(NUM_CDB), .PREG_BITS(PREG_BITS),
                .DATA_BITS(DATA_BITS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of requests at the falling edge, predict the grant set from
  // a rotated requester list, and queue the broadcast expected after the next edge.
  task automatic applyStimulus(input logic [NUM_FU-1:0] req, input bit fixedPayload);
    logic [NUM_FU-1:0][PREG_BITS-1:0] dest;
    logic [NUM_FU-1:0][DATA_BITS-1:0] data;
    logic [NUM_FU-1:0] expGrant;
    int granted[$];
    expEntry_t e;
    @(negedge clock);
    for (int i = 0; i < NUM_FU; i++) begin
      dest[i] = fixedPayload ? PREG_BITS'(i + 3) : PREG_BITS'($urandom);
      data[i] = fixedPayload ? DATA_BITS'(32'hA0 + i + 3) : DATA_BITS'($urandom);
    end
    bus.fu_req  = req;
    bus.fu_dest = dest;
    bus.fu_data = data;
    for (int j = 0; j < NUM_FU; j++) begin
      int f;
      f = (mRr + j) % NUM_FU;
      if (req[f] && granted.size() < NUM_CDB) granted.push_back(f);
    end
    expGrant = '0;
    e.valid  = '0;
    e.regs   = '0;
    e.data   = '0;
    for (int k = 0; k < granted.size(); k++) begin
      expGrant[granted[k]] = 1'b1;
      e.valid[k] = 1'b1;
      e.regs[k]  = dest[granted[k]];
      e.data[k]  = data[granted[k]];
    end
    if (granted.size() > 0) mRr = (granted[granted.size()-1] + 1) % NUM_FU;
    #1;
    lastGrant = bus.fu_grant;
    checks++;
    if (bus.fu_grant !== expGrant) begin
      errors++;
      $display("[TB] FAIL grant req=%b actual=%b expected=%b", req, bus.fu_grant, expGrant);
    end
    if (fairMode) begin
      fu1Wait = (req[1] && !bus.fu_grant[1]) ? fu1Wait + 1 : 0;
      checks++;
      if (fu1Wait > 1) begin
        errors++;
        $display("[TB] FAIL fairness FU1 consecutive waits actual=%0d allowed=1", fu1Wait);
      end
    end
    expQ.push_back(e);
  endtask

  task automatic applyDirected(input logic [NUM_FU-1:0] req, input logic [NUM_FU-1:0] want,
                               input bit fixedPayload);
    applyStimulus(req, fixedPayload);
    checks++;
    if (lastGrant !== want) begin
      errors++;
      $display("[TB] FAIL directed grant req=%b actual=%b expected=%b", req, lastGrant, want);
    end
  endtask

  // Asserts reset in the middle of a cycle that already holds a pending grant.
  task automatic midCycleReset();
    applyStimulus(4'b1111, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    expQ.delete();
    mRr = 0;
    checks++;
    if (bus.fu_grant !== '0 || bus.cdb_valid !== '0) begin
      errors++;
      $display("[TB] FAIL async reset grant=%b valid=%b expected 0/0", bus.fu_grant, bus.cdb_valid);
    end
    repeat (2) @(negedge clock);
    bus.fu_req = '0;
    reset = 1'b0;
  endtask

  task automatic checkOutput();
    expEntry_t e;
    e.valid = '0;
    e.regs  = '0;
    e.data  = '0;
    if (!reset && expQ.size() > 0) e = expQ.pop_front();
    checks++;
    if (bus.cdb_valid !== e.valid || bus.cdb_reg !== e.regs || bus.cdb_data !== e.data) begin
      errors++;
      $display("[TB] FAIL cdb actual v=%b r=%h d=%h expected v=%b r=%h d=%h",
               bus.cdb_valid, bus.cdb_reg, bus.cdb_data, e.valid, e.regs, e.data);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      checkOutput();
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    mRr      = 0;
    fu1Wait  = 0;
    fairMode = 1'b0;
    reset    = 1'b1;
    bus.fu_req  = 4'b1111;
    bus.fu_dest = '0;
    bus.fu_data = '0;
    #1;
    checks++;
    if (bus.fu_grant !== '0) begin
      errors++;
      $display("[TB] FAIL grant during reset actual=%b expected=0000", bus.fu_grant);
    end
    repeat (3) @(negedge clock);
    bus.fu_req = '0;
    reset = 1'b0;

    applyDirected(4'b1111, 4'b0011, 1'b0);
    applyDirected(4'b1111, 4'b1100, 1'b0);
    applyDirected(4'b1111, 4'b0011, 1'b0);
    applyDirected(4'b0000, 4'b0000, 1'b0);
    applyDirected(4'b0000, 4'b0000, 1'b0);
    applyDirected(4'b1111, 4'b1100, 1'b0);
    applyDirected(4'b0100, 4'b0100, 1'b1);
    applyDirected(4'b1001, 4'b1001, 1'b1);
    applyDirected(4'b0110, 4'b0110, 1'b0);

    for (int n = 0; n < 300; n++) applyStimulus(NUM_FU'($urandom), 1'b0);

    midCycleReset();
    applyDirected(4'b1111, 4'b0011, 1'b0);

    fairMode = 1'b1;
    fu1Wait  = 0;
    for (int n = 0; n < 1000; n++) applyStimulus(NUM_FU'($urandom) | 4'b0010, 1'b0);
    fairMode = 1'b0;
    applyStimulus(4'b0000, 1'b0);

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
